// File: rtl/snn_pkg.sv
// Shared constants and helpers for the spiking-neuron front end: widths, frame length,
// write-channel selectors and a saturating adder.
package snn_pkg;

    localparam int SNN_WIDTH = 16;
    localparam int SNN_FRAME = 16;

    localparam logic [1:0] CH0    = 2'd0;
    localparam logic [1:0] CH1    = 2'd1;
    localparam logic [1:0] CH2    = 2'd2;
    localparam logic [1:0] CH_ALL = 2'd3;

    // Add at one extra bit and clamp to all-ones on carry out.
    function automatic logic [SNN_WIDTH-1:0] sat_add(
        input logic [SNN_WIDTH-1:0] a,
        input logic [SNN_WIDTH-1:0] b
    );
        logic [SNN_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[SNN_WIDTH]) begin
            return {SNN_WIDTH{1'b1}};
        end else begin
            return sum[SNN_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/synapse_trace3_if.sv
// Weight-write request bus: valid/ready handshake carrying a channel select and a new weight.
interface synapse_trace3_if #(
    parameter int WIDTH = snn_pkg::SNN_WIDTH
);
    logic             wr_valid;
    logic             wr_ready;
    logic [1:0]       wr_sel;
    logic [WIDTH-1:0] wr_data;

    modport master (output wr_valid, output wr_sel, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_sel, input  wr_data, output wr_ready);
endinterface

// File: rtl/synapse_trace_ch.sv
// One synapse channel: programmable weight, rising-edge spike detect and a leaky,
// saturating postsynaptic trace.
module synapse_trace_ch
    import snn_pkg::*;
#(
    parameter int               WIDTH       = SNN_WIDTH,
    parameter int               DECAY_SHIFT = 2,
    parameter logic [WIDTH-1:0] WEIGHT_INIT = 16'd13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pre_spk,
    input  logic             clear,
    input  logic             decay_tick,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] trace
);

    logic             pre_q_r;
    logic [WIDTH-1:0] weight_r;
    logic [WIDTH-1:0] trace_r;
    logic [WIDTH-1:0] trace_nxt_s;
    logic [WIDTH-1:0] decayed_s;
    logic             event_s;

    assign event_s   = pre_spk & ~pre_q_r;
    // Subtracting a right-shifted copy can never go below zero.
    assign decayed_s = trace_r - (trace_r >> DECAY_SHIFT);
    assign trace     = trace_r;

    // Next trace: clear wins, decay is applied before the weight is added.
    always_comb begin
        trace_nxt_s = trace_r;
        if (clear) begin
            trace_nxt_s = '0;
        end else if (event_s && decay_tick) begin
            trace_nxt_s = sat_add(decayed_s, weight_r);
        end else if (event_s) begin
            trace_nxt_s = sat_add(trace_r, weight_r);
        end else if (decay_tick) begin
            trace_nxt_s = decayed_s;
        end else begin
            trace_nxt_s = trace_r;
        end
    end

    // Channel state; a write lands on the same edge that consumes the old weight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q_r  <= 1'b0;
            weight_r <= WEIGHT_INIT;
            trace_r  <= '0;
        end else begin
            pre_q_r <= pre_spk;
            trace_r <= trace_nxt_s;
            if (wr_en) begin
                weight_r <= wr_data;
            end else begin
                weight_r <= weight_r;
            end
        end
    end

endmodule

// File: rtl/synapse_trace3.sv
// Three-channel synaptic trace front end for the threshold neuron: frame counter,
// weight-write handshake/decode and three trace channels.
module synapse_trace3
    import snn_pkg::*;
#(
    parameter int WIDTH        = SNN_WIDTH,
    parameter int DECAY_PERIOD = SNN_FRAME,
    parameter int DECAY_SHIFT  = 2,
    parameter int WEIGHT_INIT  = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       pre_spk,
    input  logic             clear,
    synapse_trace3_if.slave  wr,
    output logic [WIDTH-1:0] inspk1,
    output logic [WIDTH-1:0] inspk2,
    output logic [WIDTH-1:0] inspk3,
    output logic             frame_tick
);

    localparam int CNT_W = $clog2(DECAY_PERIOD);

    logic [CNT_W-1:0] cnt_r;
    logic             decay_tick_s;
    logic             frame_tick_r;
    logic             wr_ready_r;
    logic             accept_s;
    logic [2:0]       wr_en_s;
    logic [WIDTH-1:0] trace_s [3];

    assign decay_tick_s = (cnt_r == CNT_W'(DECAY_PERIOD - 1));
    assign accept_s     = wr.wr_valid & wr_ready_r;
    assign wr.wr_ready  = wr_ready_r;
    assign frame_tick   = frame_tick_r;
    assign inspk1       = trace_s[0];
    assign inspk2       = trace_s[1];
    assign inspk3       = trace_s[2];

    // Frame counter and its one-clock-late tick output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r        <= '0;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= decay_tick_s;
            if (decay_tick_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Ready drops for exactly one clock after each accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ready_r <= 1'b1;
        end else if (accept_s) begin
            wr_ready_r <= 1'b0;
        end else begin
            wr_ready_r <= 1'b1;
        end
    end

    // Route an accepted write to its channel, or to all three on broadcast.
    always_comb begin
        wr_en_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (accept_s && ((wr.wr_sel == CH_ALL) || (wr.wr_sel == 2'(i)))) begin
                wr_en_s[i] = 1'b1;
            end else begin
                wr_en_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_ch
        synapse_trace_ch #(
            .WIDTH       (WIDTH),
            .DECAY_SHIFT (DECAY_SHIFT),
            .WEIGHT_INIT (WIDTH'(WEIGHT_INIT))
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .pre_spk    (pre_spk[g]),
            .clear      (clear),
            .decay_tick (decay_tick_s),
            .wr_en      (wr_en_s[g]),
            .wr_data    (wr.wr_data),
            .trace      (trace_s[g])
        );
    end

endmodule

// File: tb/tb_synapse_trace3.sv
// Self-checking bench for synapse_trace3: directed table, multi-cycle corner sequences
// and randomized traffic against an arithmetic reference model.
module tb_synapse_trace3;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  pre_spk;
    logic        clear;
    logic [15:0] inspk1, inspk2, inspk3;
    logic        frame_tick;

    synapse_trace3_if #(.WIDTH(16)) wr_bus ();

    synapse_trace3 dut (
        .clk        (clk),
        .reset      (reset),
        .pre_spk    (pre_spk),
        .clear      (clear),
        .wr         (wr_bus),
        .inspk1     (inspk1),
        .inspk2     (inspk2),
        .inspk3     (inspk3),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state, in plain integers.
    int       m_tr [3];
    int       m_w  [3];
    int       m_cnt;
    logic [2:0] m_pre;
    logic     m_ready;
    logic     m_ft;

    typedef struct {
        logic [2:0]  pre;
        logic [15:0] exp1;
        logic        exp_ft;
    } vec_t;
    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_tr[i] = 0;
            m_w[i]  = 13;
        end
        m_cnt   = 0;
        m_pre   = 3'b000;
        m_ready = 1'b1;
        m_ft    = 1'b0;
    endtask

    // Advance model and DUT by one clock, then compare every output.
    task automatic tick();
        int   nt [3];
        logic dec;
        logic acc;
        dec = (m_cnt == 15);
        acc = wr_bus.wr_valid && m_ready;
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                nt[i] = 0;
            end else begin
                nt[i] = m_tr[i];
                if (dec) nt[i] = nt[i] - nt[i] / 4;
                if (pre_spk[i] && !m_pre[i]) nt[i] = nt[i] + m_w[i];
                if (nt[i] > 65535) nt[i] = 65535;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (acc && (wr_bus.wr_sel == 2'd3 || int'(wr_bus.wr_sel) == i)) m_w[i] = int'(wr_bus.wr_data);
            m_tr[i] = nt[i];
        end
        m_ready = !acc;
        m_ft    = dec;
        m_cnt   = (m_cnt + 1) % 16;
        m_pre   = pre_spk;
        @(posedge clk);
        #1;
        chk("inspk1", {16'd0, inspk1}, m_tr[0]);
        chk("inspk2", {16'd0, inspk2}, m_tr[1]);
        chk("inspk3", {16'd0, inspk3}, m_tr[2]);
        chk("frame_tick", {31'd0, frame_tick}, {31'd0, m_ft});
        chk("wr_ready", {31'd0, wr_bus.wr_ready}, {31'd0, m_ready});
    endtask

    initial begin
        reset           = 1'b1;
        pre_spk         = 3'b000;
        clear           = 1'b0;
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_sel   = 2'd0;
        wr_bus.wr_data  = 16'd0;
        model_reset();

        for (int i = 0; i < 17; i++) begin
            vecs[i].pre    = (i >= 3 && i <= 5) ? 3'b001 : 3'b000;
            vecs[i].exp1   = (i < 3) ? 16'd0 : (i < 15) ? 16'd13 : 16'd10;
            vecs[i].exp_ft = (i == 15);
        end

        #1;
        chk("rst_inspk1", {16'd0, inspk1}, 32'd0);
        chk("rst_inspk2", {16'd0, inspk2}, 32'd0);
        chk("rst_inspk3", {16'd0, inspk3}, 32'd0);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_bus.wr_ready}, 32'd1);
        #11 reset = 1'b0;

        // Spike on ch0 across cnt=3..5, decay at the frame wrap.
        for (int i = 0; i < 17; i++) begin
            pre_spk = vecs[i].pre;
            tick();
            chk("tbl_inspk1", {16'd0, inspk1}, {16'd0, vecs[i].exp1});
            chk("tbl_inspk2", {16'd0, inspk2}, 32'd0);
            chk("tbl_frame_tick", {31'd0, frame_tick}, {31'd0, vecs[i].exp_ft});
        end

        // Trace 100, then an event coinciding with decay: 100-25+13.
        clear = 1'b1; tick(); clear = 1'b0;
        wr_bus.wr_valid = 1'b1; wr_bus.wr_sel = 2'd0; wr_bus.wr_data = 16'd100; tick();
        wr_bus.wr_valid = 1'b0;
        pre_spk = 3'b001; tick();
        chk("trace100", {16'd0, inspk1}, 32'd100);
        pre_spk = 3'b000;
        wr_bus.wr_valid = 1'b1; wr_bus.wr_data = 16'd13; tick();
        wr_bus.wr_valid = 1'b0;
        for (int k = 0; k < 16 && m_cnt != 15; k++) tick();
        pre_spk = 3'b001; tick();
        chk("decay_plus_add", {16'd0, inspk1}, 32'd88);
        pre_spk = 3'b000;

        // Broadcast a large weight, two ch1 spikes saturate.
        wr_bus.wr_valid = 1'b1; wr_bus.wr_sel = 2'd3; wr_bus.wr_data = 16'hF000; tick();
        wr_bus.wr_valid = 1'b0;
        pre_spk = 3'b010; tick();
        chk("bcast_first", {16'd0, inspk2}, 32'h0000F000);
        pre_spk = 3'b000; tick();
        pre_spk = 3'b010; tick();
        chk("saturate", {16'd0, inspk2}, 32'h0000FFFF);
        pre_spk = 3'b000;
        wr_bus.wr_valid = 1'b1; wr_bus.wr_data = 16'd13; tick();
        wr_bus.wr_valid = 1'b0; tick();

        // Held write request: accept, one clock not ready, accept again; same-clock event uses old weight.
        chk("ready_before", {31'd0, wr_bus.wr_ready}, 32'd1);
        wr_bus.wr_valid = 1'b1; wr_bus.wr_sel = 2'd2; wr_bus.wr_data = 16'd20;
        pre_spk = 3'b100; tick();
        chk("old_weight_add", {16'd0, inspk3}, 32'd13);
        chk("ready_low", {31'd0, wr_bus.wr_ready}, 32'd0);
        tick();
        chk("ready_back", {31'd0, wr_bus.wr_ready}, 32'd1);
        tick();
        chk("ready_low_again", {31'd0, wr_bus.wr_ready}, 32'd0);
        wr_bus.wr_valid = 1'b0;
        pre_spk = 3'b000; tick();

        // Clear with nonzero traces and a simultaneous event.
        pre_spk = 3'b001; clear = 1'b1; tick();
        chk("clear1", {16'd0, inspk1}, 32'd0);
        chk("clear2", {16'd0, inspk2}, 32'd0);
        chk("clear3", {16'd0, inspk3}, 32'd0);
        clear = 1'b0;
        pre_spk = 3'b101; tick();
        chk("weight_kept", {16'd0, inspk3}, 32'd20);
        pre_spk = 3'b000;

        // Async reset right after a frame tick, traces nonzero.
        for (int k = 0; k < 17 && !m_ft; k++) tick();
        reset = 1'b1;
        #2;
        chk("arst_inspk1", {16'd0, inspk1}, 32'd0);
        chk("arst_inspk3", {16'd0, inspk3}, 32'd0);
        chk("arst_frame_tick", {31'd0, frame_tick}, 32'd0);
        chk("arst_wr_ready", {31'd0, wr_bus.wr_ready}, 32'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        pre_spk = 3'b111; tick();
        chk("post_rst_w1", {16'd0, inspk1}, 32'd13);
        chk("post_rst_w2", {16'd0, inspk2}, 32'd13);
        chk("post_rst_w3", {16'd0, inspk3}, 32'd13);
        pre_spk = 3'b000;
        for (int k = 1; k < 17; k++) begin
            tick();
            chk("post_rst_frame", {31'd0, frame_tick}, {31'd0, (k == 15)});
        end

        // Randomized traffic with a well-behaved requester.
        for (int n = 0; n < 600; n++) begin
            pre_spk = 3'($urandom_range(0, 7));
            clear   = ($urandom_range(0, 31) == 0);
            if (wr_bus.wr_valid && !m_ready) begin
                wr_bus.wr_valid = 1'b0;
            end else if (!wr_bus.wr_valid && $urandom_range(0, 3) == 0) begin
                wr_bus.wr_valid = 1'b1;
                wr_bus.wr_sel   = 2'($urandom_range(0, 3));
                wr_bus.wr_data  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
